alsu_display_mux: RTL and testbench
===================================

# alsu_display_mux

Parametrised, time-multiplexed seven-segment driver for the ALSU result, superseding the fixed four-digit display driver. It captures the ALSU result on `valid` and holds it in a double buffer that updates only at frame boundaries, so the display never tears. It renders the held value as hex, with optional signed (sign-magnitude) rendering and leading-zero blanking, and shows dashes when no result is held. It sits between the ALSU output and the board's common-anode display pins.

## Interface
- `DATA_W`, 6, width of `out_ALU`; 1..16.
- `NUM_DIGITS`, 4, number of display digits; 2..8. Must satisfy 4*(NUM_DIGITS-1) >= DATA_W+1.
- `SCAN_DIV`, 262144, clock cycles each digit is lit; >= 2.

Ports:
- `clock_100Mhz`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `valid`  in  1  capture strobe for `out_ALU`.
- `out_ALU`  in  DATA_W  ALSU result.
- `clear`  in  1  synchronous; drops the held result, so dashes are shown.
- `signed_mode`  in  1  1 = treat the value as two's complement.
- `blank_lz`  in  1  1 = blank leading-zero digits.
- `Anode_Activate`  out  NUM_DIGITS  active-low digit enables; one-hot-low while scanning.
- `LED_out`  out  7  active-low segments, bit 6 = a .. bit 0 = g.
- `frame_pulse`  out  1  one-cycle pulse on the last cycle of each scan frame.

## Operation
- **Capture register.** On a cycle with `valid`=1: `data_reg` <= `out_ALU`, `have_data` <= 1.
  - `clear`=1 sets `have_data` <= 0.
  - `clear` has priority over `valid` in the same cycle.
- **Scan counters.**
  - Prescaler `pre` counts 0..SCAN_DIV-1 and wraps.
  - Digit index `idx` advances when `pre`=SCAN_DIV-1, ordered 0..NUM_DIGITS-1 and wrapping.
  - Digit 0 is the least-significant digit.
- **Frame boundary.** Frame end is the cycle with `pre`=SCAN_DIV-1 and `idx`=NUM_DIGITS-1. In that cycle the display buffer loads `data_reg`, `have_data`, `signed_mode` and `blank_lz`.
  - A `valid` or `clear` in the boundary cycle itself is not seen until the following frame.
- **Rendering** uses the display buffer only.
  - `have_data`=0: every digit shows dash (1111110).
  - Unsigned: nibble k of the value is shown on digit k; nibbles beyond DATA_W are 0.
  - Signed with MSB=1: the magnitude is the negation computed at DATA_W+1 bits (−32 at DATA_W=6 gives 0x20). The magnitude fills digits 0..NUM_DIGITS-2.
  - Sign placement with `blank_lz`=0: the sign goes on digit NUM_DIGITS-1.
  - Sign placement with `blank_lz`=1: the sign goes on the digit directly above the highest non-zero magnitude digit.
  - Signed with MSB=0: rendered as unsigned.
  - Leading-zero blanking: digits above the highest non-zero digit show blank (1111111). Digit 0 is never blanked, so zero shows "0".
- **Glyphs** (active low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - dash=1111110, blank=1111111

## Timing
- **Reset values:**
  - `Anode_Activate` = all ones (all digits off).
  - `LED_out` = 1111111, `frame_pulse` = 0.
  - `pre`=0, `idx`=0, `have_data`=0, display buffer holds dashes.
- **Registered outputs.** `Anode_Activate` and `LED_out` are registered and reflect `idx` with 1 cycle latency.
  - First lit digit: digit 0, in the first cycle after the first clock edge following reset release.
  - Each digit then stays lit for exactly SCAN_DIV cycles.
- **`frame_pulse`** is combinational from the counters and is high exactly in the frame-end cycle.
- **Capture-to-display latency.** From `valid` to the new value appearing is from 1 cycle up to one full frame (NUM_DIGITS*SCAN_DIV cycles), plus 1 cycle of output registering.
- **Multiple captures.** Multiple `valid` pulses within one frame: the last one wins.
- **Reset mid-frame.** Outputs go to their reset values immediately, without waiting for a clock edge. The held result is lost.

## Test plan
Common setup: DATA_W=6, NUM_DIGITS=4, SCAN_DIV=4.

1. **Reset, then idle with no `valid`.**
   - During reset: `Anode_Activate`=1111 and `LED_out`=1111111.
   - After release: anodes step 1110, 1101, 1011, 0111, each for 4 cycles.
   - `LED_out`=1111110 on every digit.
   - `frame_pulse` fires every 16 cycles.
2. **Unsigned, no blanking.** `valid` with `out_ALU`=6'h2D, `signed_mode`=0, `blank_lz`=0.
   - Before the frame boundary: dashes continue.
   - Next frame: digit 0=1000010, digit 1=0010010, digits 2 and 3=0000001.
3. **Unsigned with blanking.** Same as scenario 2 with `blank_lz`=1.
   - Digits 2 and 3 show 1111111.
   - Then `out_ALU`=0: digit 0=0000001, digits 1..3 blank.
4. **Signed values.** `signed_mode`=1.
   - `out_ALU`=6'b111011 (−5), `blank_lz`=1: digit 0=0100100, digit 1=1111110, digits 2 and 3 blank.
   - Same value with `blank_lz`=0: digit 3=1111110, digits 1 and 2=0000001.
   - `out_ALU`=6'b100000 (−32): digit 0=0000001, digit 1=0010010, sign on digit 2 (`blank_lz`=1).
5. **Boundary-cycle capture.** `valid`=1 with 6'h11 exactly in the `frame_pulse` cycle.
   - The following frame still shows the old value.
   - The frame after that shows "11".
6. **Clear priority, and reset mid-frame.**
   - `clear` and `valid` in the same cycle: dashes from the next frame.
   - `reset` asserted mid-digit: outputs are all-off without waiting for a clock edge, then scanning restarts at digit 0 showing dashes.

Source files
------------

// File: rtl/alsu_display_mux.sv
// Time-multiplexed seven-segment driver for the ALSU result.
// Frame-synchronous double buffer; hex, sign-magnitude and zero-blanking.
module alsu_display_mux #(
  parameter int DATA_W     = 6,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 262144
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [DATA_W-1:0]     out_ALU,
  input  logic                  clear,
  input  logic                  signed_mode,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out,
  output logic                  frame_pulse
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int XW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [PW-1:0]     pre;
  logic [IW-1:0]     idx;
  logic              pre_wrap;
  logic              frame_end;
  logic [DATA_W-1:0] data_reg;
  logic              have_data;
  logic [DATA_W-1:0] disp_data;
  logic              disp_have;
  logic              disp_signed;
  logic              disp_blz;
  logic [DATA_W:0]   sext;
  logic [DATA_W:0]   mag;
  logic [XW-1:0]     mag_ext;
  logic              neg;
  logic [3:0]        nibs [NUM_DIGITS];
  logic [IW-1:0]     hi;
  logic [IW-1:0]     sign_pos;
  logic [6:0]        seg;

  assign pre_wrap    = (pre == PRE_LAST);
  assign frame_end   = pre_wrap && (idx == IDX_LAST);
  assign frame_pulse = frame_end;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      4'hF: g = 7'b0111000;
    endcase
    return g;
  endfunction

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre_wrap) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      data_reg  <= '0;
      have_data <= 1'b0;
    end else if (clear) begin
      have_data <= 1'b0;
    end else if (valid) begin
      data_reg  <= out_ALU;
      have_data <= 1'b1;
    end
  end

  // Display buffer only changes at frame end so a frame never tears.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      disp_data   <= '0;
      disp_have   <= 1'b0;
      disp_signed <= 1'b0;
      disp_blz    <= 1'b0;
    end else if (frame_end) begin
      disp_data   <= data_reg;
      disp_have   <= have_data;
      disp_signed <= signed_mode;
      disp_blz    <= blank_lz;
    end
  end

  assign sext    = {disp_data[DATA_W-1], disp_data};
  assign neg     = disp_signed & disp_data[DATA_W-1];
  assign mag     = neg ? -sext : {1'b0, disp_data};
  assign mag_ext = {{(XW-DATA_W-1){1'b0}}, mag};

  always_comb begin
    hi = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nibs[k] = mag_ext[4*k +: 4];
      if (nibs[k] != 4'h0) hi = IW'(k);
    end
  end

  assign sign_pos = disp_blz ? hi + 1'b1 : IDX_LAST;

  always_comb begin
    seg = SEG_DASH;
    if (!disp_have)
      seg = SEG_DASH;
    else if (neg && idx == sign_pos)
      seg = SEG_DASH;
    else if (disp_blz && idx > hi)
      seg = SEG_BLANK;
    else
      seg = glyph(nibs[idx]);
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      Anode_Activate <= '1;
      LED_out        <= SEG_BLANK;
    end else begin
      Anode_Activate <= ~(NUM_DIGITS'(1) << idx);
      LED_out        <= seg;
    end
  end

endmodule

// File: tb/tb_alsu_display_mux.sv
// Directed vector bench for alsu_display_mux.
// Checks every scanned cycle against hand-computed frames.
module tb_alsu_display_mux;

  localparam logic [6:0] D  = 7'b1111110;
  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] GC = 7'b0110001;
  localparam logic [6:0] GD = 7'b1000010;
  localparam logic [6:0] GF = 7'b0111000;

  typedef logic [3:0][6:0] frame_t;

  typedef struct {
    string      name;
    logic [5:0] data;
    logic       sm;
    logic       blz;
    logic       clr;
    frame_t     exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [5:0] out_alu = '0;
  logic       clear = 1'b0;
  logic       signed_mode = 1'b0;
  logic       blank_lz = 1'b0;
  logic [3:0] anode;
  logic [6:0] led;
  logic       fp;

  int passed = 0;
  int total  = 0;

  alsu_display_mux #(
    .DATA_W(6), .NUM_DIGITS(4), .SCAN_DIV(4)
  ) dut (
    .clock_100Mhz  (clk),
    .reset         (reset),
    .valid         (valid),
    .out_ALU       (out_alu),
    .clear         (clear),
    .signed_mode   (signed_mode),
    .blank_lz      (blank_lz),
    .Anode_Activate(anode),
    .LED_out       (led),
    .frame_pulse   (fp)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int i,
                       input logic [3:0] ea, input logic [6:0] el,
                       input logic ef);
    total++;
    if (anode === ea && led === el && fp === ef)
      passed++;
    else
      $display("FAIL %s[%0d]: got an=%b led=%b fp=%b, want an=%b led=%b fp=%b",
               name, i, anode, led, fp, ea, el, ef);
  endtask

  // One full frame starting at a digit-0 boundary; drops strobes after cycle 0.
  task automatic check_frame(input string name, input frame_t exp);
    logic [3:0] ea;
    int d;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        valid = 1'b0;
        clear = 1'b0;
      end
      d  = i / 4;
      ea = ~(4'b0001 << d);
      check(name, i, ea, exp[d], i == 14);
    end
  endtask

  vec_t   vecs [10];
  frame_t prev;
  frame_t dash_f;

  initial begin
    dash_f = {D, D, D, D};
    vecs[0] = '{"uns_2d",     6'h2D, 1'b0, 1'b0, 1'b0, {G0, G0, G2, GD}};
    vecs[1] = '{"uns_2d_blz", 6'h2D, 1'b0, 1'b1, 1'b0, {B, B, G2, GD}};
    vecs[2] = '{"zero_blz",   6'h00, 1'b0, 1'b1, 1'b0, {B, B, B, G0}};
    vecs[3] = '{"neg5_blz",   6'h3B, 1'b1, 1'b1, 1'b0, {B, B, D, G5}};
    vecs[4] = '{"neg5",       6'h3B, 1'b1, 1'b0, 1'b0, {D, G0, G0, G5}};
    vecs[5] = '{"neg32_blz",  6'h20, 1'b1, 1'b1, 1'b0, {B, D, G2, G0}};
    vecs[6] = '{"neg32",      6'h20, 1'b1, 1'b0, 1'b0, {D, G0, G2, G0}};
    vecs[7] = '{"pos_signed", 6'h1F, 1'b1, 1'b1, 1'b0, {B, B, G1, GF}};
    vecs[8] = '{"clr_valid",  6'h15, 1'b0, 1'b1, 1'b1, {D, D, D, D}};
    vecs[9] = '{"uns_3f_blz", 6'h3F, 1'b0, 1'b1, 1'b0, {B, B, G3, GF}};

    step(3);
    check("reset_hold", 0, 4'b1111, B, 1'b0);
    reset = 1'b0;
    check_frame("idle0", dash_f);
    check_frame("idle1", dash_f);
    prev = dash_f;

    for (int v = 0; v < 10; v++) begin
      out_alu     = vecs[v].data;
      signed_mode = vecs[v].sm;
      blank_lz    = vecs[v].blz;
      clear       = vecs[v].clr;
      valid       = 1'b1;
      check_frame({vecs[v].name, "_old"}, prev);
      check_frame(vecs[v].name, vecs[v].exp);
      prev = vecs[v].exp;
    end

    // Several captures in one frame: only the last is shown.
    valid = 1'b1;
    out_alu = 6'h05;
    step(1);
    out_alu = 6'h0A;
    step(1);
    out_alu = 6'h2C;
    step(1);
    valid = 1'b0;
    step(13);
    check_frame("last_wins", {B, B, G2, GC});

    // Capture in the boundary cycle lands one frame later.
    step(15);
    check("boundary_fp", 0, 4'b0111, B, 1'b1);
    valid = 1'b1;
    out_alu = 6'h11;
    step(1);
    valid = 1'b0;
    check_frame("bnd_old", {B, B, G2, GC});
    check_frame("bnd_new", {B, B, G1, G1});

    step(5);
    #2 reset = 1'b1;
    #1 check("reset_async", 0, 4'b1111, B, 1'b0);
    step(2);
    check("reset_held", 0, 4'b1111, B, 1'b0);
    reset = 1'b0;
    check_frame("post_reset", dash_f);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
